// File: rtl/seq_shift_rotate_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_rotate_unit
// Description : Iterative shift/rotate engine. Applies up to STEP positions
//               of ROL/ROR/SLL/SRL/SRA per cycle to a working register until
//               the requested amount is consumed. Valid/ready on both sides.
//               Carry-out reports the last bit shifted or wrapped out.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_rotate_unit #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c_out
);

  localparam logic [2:0]       C_OP_ROL = 3'd0;
  localparam logic [2:0]       C_OP_ROR = 3'd1;
  localparam logic [2:0]       C_OP_SLL = 3'd2;
  localparam logic [2:0]       C_OP_SRL = 3'd3;
  localparam logic [2:0]       C_OP_SRA = 3'd4;
  localparam logic [AMT_W-1:0] C_STEP   = AMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_work;
  logic [2:0]         r_op;
  logic [AMT_W-1:0]   r_rem;
  logic               r_cout;
  logic [WIDTH-1:0]   w_step_work;
  logic               w_step_cout;
  logic               w_last;
  logic               w_skip;

  // The cycle that consumes the remaining amount is the final BUSY cycle.
  assign w_last = (r_rem <= C_STEP);

  // Zero amount or reserved op needs no shifting: result is the operand.
  assign w_skip = (amt == '0) || (op > C_OP_SRA);

  // One BUSY cycle: a chain of single-position moves, only the first
  // min(STEP, rem) of which are enabled; carry tracks the last bit moved out.
  always_comb begin
    w_step_work = r_work;
    w_step_cout = r_cout;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(r_rem)) begin
        case (r_op)
          C_OP_ROL: begin
            w_step_cout = w_step_work[WIDTH-1];
            w_step_work = {w_step_work[WIDTH-2:0], w_step_work[WIDTH-1]};
          end
          C_OP_ROR: begin
            w_step_cout = w_step_work[0];
            w_step_work = {w_step_work[0], w_step_work[WIDTH-1:1]};
          end
          C_OP_SLL: begin
            w_step_cout = w_step_work[WIDTH-1];
            w_step_work = {w_step_work[WIDTH-2:0], 1'b0};
          end
          C_OP_SRL: begin
            w_step_cout = w_step_work[0];
            w_step_work = {1'b0, w_step_work[WIDTH-1:1]};
          end
          C_OP_SRA: begin
            w_step_cout = w_step_work[0];
            w_step_work = {w_step_work[WIDTH-1], w_step_work[WIDTH-1:1]};
          end
          default: begin
            w_step_cout = w_step_cout;
            w_step_work = w_step_work;
          end
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs derived from the state.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_skip ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the request on accept, advance one step per BUSY cycle,
  // hold everything in DONE so y/c_out stay stable until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work <= '0;
      r_op   <= '0;
      r_rem  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work <= a;
            r_op   <= op;
            r_rem  <= amt;
            r_cout <= 1'b0;
          end
        end
        S_BUSY: begin
          r_work <= w_step_work;
          r_cout <= w_step_cout;
          r_rem  <= w_last ? '0 : (r_rem - C_STEP);
        end
        default: begin
          r_work <= r_work;
        end
      endcase
    end
  end

  assign y     = r_work;
  assign c_out = r_cout;

endmodule
`default_nettype wire

// File: doc/seq_shift_rotate_unit.md
Name: seq_shift_rotate_unit

Overview:
Parametrised, multi-cycle shift/rotate engine for the datapath. It is the successor to the fixed 32-bit, 1/2-bit rotate unit and differs from it in these ways:
- generic WIDTH
- variable amount 0..WIDTH-1
- five modes: rotate left/right, logical left/right, arithmetic right
- iterative execution of STEP bits per cycle
- valid/ready handshakes on both sides

It sits beside the ALU and serves variable shifts and rotates whose amount comes from a register. Carry-out reports the last bit shifted or wrapped out.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- STEP, 1, maximum bit positions shifted per BUSY cycle; legal range 1..WIDTH-1.
- AMT_W, $clog2(WIDTH), localparam giving the shift-amount width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- a  in  WIDTH  operand
- amt  in  AMT_W  shift amount
- op  in  3  0=ROL, 1=ROR, 2=SLL, 3=SRL, 4=SRA, 5..7 reserved
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- c_out  out  1  last bit shifted/wrapped out

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). Every register updates only on a clk rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, c_out=0, remaining count=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept occurs when in_valid && in_ready at an edge. On accept, latch a into the working register, latch op, set rem=amt, clear c_out.
    - Go to DONE if amt==0 or op is reserved.
    - Otherwise go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each edge applies k=min(STEP, rem) positions of the latched op to the working register and sets rem-=k. c_out takes the last bit moved out in that step. Go to DONE when rem≤STEP, i.e. on the final step.
  - DONE: out_valid=1, in_ready=0. y and c_out are held stable. When out_ready=1 at an edge, the result is consumed and the FSM returns to IDLE. A new request cannot be accepted in the same cycle as the result handshake.
- Latency: out_valid rises 1+ceil(amt/STEP) cycles after the accept edge. Throughput is one operation per latency+1 cycles, minimum.
- y is the working register; it is only valid when out_valid=1.
- Mode semantics after n=amt total positions (n≥1):
  - ROL: y = {a[W-1-n:0], a[W-1:W-n]}, c_out = a[W-n].
  - ROR: y = {a[n-1:0], a[W-1:n]}, c_out = a[n-1].
  - SLL: zero-fill from the LSB, c_out = a[W-n].
  - SRL: zero-fill from the MSB, c_out = a[n-1].
  - SRA: fill from the MSB with a[W-1], c_out = a[n-1].
- These semantics match the legacy unit for WIDTH=32, n∈{1,2}: ROL1 c=a[31], ROL2 c=a[30], ROR1 c=a[0], ROR2 c=a[1].
- Boundary cases:
  - amt=0 (any op): y=a, c_out=0, latency 1.
  - Reserved op: y=a, c_out=0, latency 1, no error flag.
  - amt=WIDTH-1 is legal; for ROL/ROR it is equivalent to a rotate by 1 in the opposite direction, but c_out still follows the formulas above.
  - Step split: when rem<STEP, only rem positions are applied in that cycle.
  - Inputs a/amt/op changing while BUSY or DONE have no effect.
  - out_ready held low keeps DONE and its outputs indefinitely.
  - in_valid is ignored while in_ready=0; no request is dropped silently because the producer must hold it.
  - reset in any state (mid-BUSY, DONE) takes effect at the next edge: the in-flight operation is discarded and the outputs return to their reset values.

Test Plan:
- WIDTH=32, STEP=1: ROL a=0x80000001, amt=1 → y=0x00000003, c_out=1, out_valid 2 cycles after accept.
- ROR a=0x00000002, amt=2, STEP=1 → y=0x80000000, c_out=1, latency 3; in_ready=0 throughout.
- STEP=4: SRA a=0x80000010, amt=4 → y=0xF8000001, c_out=0, latency 2. Then SRL with the same inputs → y=0x08000001, c_out=0.
- STEP=4: SLL a=0xFFFFFFFF, amt=31 → y=0x80000000, c_out=1, latency 9 (eight steps, last step partial: 3 bits).
- amt=0 with op=ROL, and a separate request with op=6, both a=0x12345678 → y=0x12345678, c_out=0, latency 1. Hold out_ready=0 for 5 cycles → y, c_out, out_valid stable, in_ready=0, and a concurrent in_valid is not accepted.
- Assert reset for 1 cycle during BUSY of ROL amt=20, STEP=1 → next cycle in_ready=1, out_valid=0, y=0, c_out=0. A subsequent ROL a=0x1, amt=3 → y=0x8, c_out=0.
